calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Sequencing controller for the mini-project calculator datapath. It collects two sign-magnitude 4-bit operands and an operation code from switches, one field per enter-button pulse. It then drives the registered operands onto the shared Operation0..3 combinational units and waits a fixed settle interval. Finally it captures the selected unit's six BCD display digits into a held display register.

## Interface

Parameters:
- SETTLE_CYCLES, default 4: number of clock periods operands are held stable before result capture. Legal range is 1..15.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_enter  input  1  single-cycle enter pulse, already debounced and edge-detected upstream.
- btn_clear  input  1  single-cycle clear pulse.
- sw_value  input  4  operand magnitude switches; legal range 0..9.
- sw_sign  input  1  operand sign switch; 1 means negative.
- sw_op  input  2  operation select switches (0..3 selects Operation0..3).
- res_digits  input  24  output of the external op mux, wired as {d6,d5,d4,d3,d2,d1}, 4 bits per digit.
- operandX  output  4  registered X magnitude, drives every Operation unit.
- signX  output  1  registered X sign.
- operandY  output  4  registered Y magnitude.
- signY  output  1  registered Y sign.
- op_sel  output  2  registered operation select, drives the external mux.
- disp  output  24  held display digits {d6..d1}.
- state  output  3  current FSM state, for LEDs and debug.
- result_valid  output  1  high while disp holds a completed result.
- err  output  1  one-cycle pulse on rejected input.

## Operation

- States and encodings: GET_X=0, GET_Y=1, GET_OP=2, SETTLE=3, SHOW=4. Encodings 5..7 are illegal and go to GET_X on the next edge.
- GET_X:
  - On btn_enter with sw_value<=9: load operandX<=sw_value and signX<=sw_sign, then go to GET_Y.
  - On btn_enter with sw_value>9: pulse err for one cycle, keep operandX, stay in GET_X.
- GET_Y: same rules as GET_X, loading operandY/signY; a legal enter goes to GET_OP.
- GET_OP: on btn_enter, op_sel<=sw_op, clear the settle counter, go to SETTLE. Every sw_op value is legal.
- SETTLE:
  - The counter increments each cycle.
  - On the cycle the counter equals SETTLE_CYCLES-1: disp<=res_digits, result_valid<=1, go to SHOW.
  - btn_enter is ignored in this state.
- SHOW:
  - disp and operands are held.
  - On btn_enter: disp<=0, result_valid<=0, go to GET_X. Operand registers keep their values until overwritten.
- btn_clear in any state: go to GET_X; operandX, operandY, signX, signY, op_sel, disp, counter and result_valid all <=0.
  - btn_clear has priority over btn_enter when both are high.
- Negative zero (sign=1, value=0) is accepted and passed to the datapath unchanged. The sequencer does no arithmetic.
- operandX/Y, signX/Y and op_sel change only on accepted enters or on clear/reset. They are never modified in SETTLE or SHOW.
- Switch inputs are sampled only on the edge where btn_enter is high.

## Timing

- Reset values: state=GET_X, all operand/sign/op_sel registers 0, disp=0, result_valid=0, err=0, counter=0.
- Reset asserted mid-operation (any state) returns everything to these values at the next edge; reset overrides both buttons.
- Field capture latency: an enter sampled at edge E shows the new operand/op_sel and the next state after E.
- Result latency:
  - The GET_OP enter is sampled at edge E; SETTLE occupies the SETTLE_CYCLES periods after E.
  - disp, result_valid and state=SHOW become visible after edge E+SETTLE_CYCLES.
  - res_digits is sampled at that edge only.
- err is high for exactly the one cycle following the rejected enter edge.
- Back-to-back enters on consecutive cycles are each accepted in turn. There is no minimum spacing, except that enters during SETTLE are dropped.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- X then Y then operation:
  - Stimulus: SETTLE_CYCLES=4; enter with value=7/sign=1; enter with value=0/sign=1; enter with op=0; res_digits driven to 24'h000107.
  - Required: operandX=7, signX=1, operandY=0, signY=1, op_sel=0.
  - Required: disp=24'h000107 and result_valid=1 exactly 4 edges after the op enter; state=4.
- Range check: enter with sw_value=12 in GET_X.
  - Required: err high for 1 cycle, state stays 0, operandX unchanged.
  - Then enter with sw_value=9: operandX=9, state=1.
- Enter ignored in SETTLE: pulse btn_enter on the 2nd SETTLE cycle.
  - Required: no state change, and capture still happens at E+4.
  - res_digits changed mid-SETTLE: disp shows the value present at the capture edge.
- Clear handling:
  - btn_clear while in GET_OP: state=0, and all operands, op_sel and disp become 0.
  - btn_clear and btn_enter high together in SHOW: clear wins, state=0, disp=0.
- Reset mid-operation: assert reset during SETTLE with the counter at 2.
  - Required: the next edge shows all reset values, result_valid=0, and no capture occurs.
- Restart from SHOW: enter in SHOW.
  - Required: disp=0, result_valid=0, state=0, and the old operandX is still visible until the next X enter.

Source files
------------

// File: rtl/calc_sequencer.sv
// Operand/operation entry sequencer for the calculator datapath: collects X, Y and
// the op select one enter pulse at a time, waits a settle interval, then latches the result digits.
module calc_sequencer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_enter,
  input  logic        btn_clear,
  input  logic [3:0]  sw_value,
  input  logic        sw_sign,
  input  logic [1:0]  sw_op,
  input  logic [23:0] res_digits,
  output logic [3:0]  operandX,
  output logic        signX,
  output logic [3:0]  operandY,
  output logic        signY,
  output logic [1:0]  op_sel,
  output logic [23:0] disp,
  output logic [2:0]  state,
  output logic        result_valid,
  output logic        err
);

  typedef enum logic [2:0] {
    GET_X  = 3'd0,
    GET_Y  = 3'd1,
    GET_OP = 3'd2,
    SETTLE = 3'd3,
    SHOW   = 3'd4
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  opx_q, opy_q, cnt_q;
  logic        sx_q, sy_q, valid_q, err_q;
  logic [1:0]  op_q;
  logic [23:0] disp_q;

  // btn_enter/btn_clear are one-cycle pulses; a field is taken only on the edge
  // where btn_enter is high, and clear outranks enter whenever both are present.
  always_ff @(posedge clk) begin
    if (reset || btn_clear) begin
      state_q <= GET_X;
      opx_q   <= 4'd0;
      sx_q    <= 1'b0;
      opy_q   <= 4'd0;
      sy_q    <= 1'b0;
      op_q    <= 2'd0;
      disp_q  <= 24'd0;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        GET_X: begin
          if (btn_enter) begin
            if (sw_value <= 4'd9) begin
              opx_q   <= sw_value;
              sx_q    <= sw_sign;
              state_q <= GET_Y;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        GET_Y: begin
          if (btn_enter) begin
            if (sw_value <= 4'd9) begin
              opy_q   <= sw_value;
              sy_q    <= sw_sign;
              state_q <= GET_OP;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        GET_OP: begin
          if (btn_enter) begin
            op_q    <= sw_op;
            cnt_q   <= 4'd0;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          // Enters are dropped here; the datapath must see stable operands.
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            disp_q  <= res_digits;
            valid_q <= 1'b1;
            state_q <= SHOW;
          end
        end
        SHOW: begin
          if (btn_enter) begin
            disp_q  <= 24'd0;
            valid_q <= 1'b0;
            state_q <= GET_X;
          end
        end
        default: state_q <= GET_X;
      endcase
    end
  end

  assign operandX     = opx_q;
  assign signX        = sx_q;
  assign operandY     = opy_q;
  assign signY        = sy_q;
  assign op_sel       = op_q;
  assign disp         = disp_q;
  assign state        = state_q;
  assign result_valid = valid_q;
  assign err          = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: a directed vector table for the documented scenarios,
// then random button/switch traffic checked against a phase-level reference model.
module tb_calc_sequencer;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        reset, btn_enter, btn_clear, sw_sign;
  logic [3:0]  sw_value;
  logic [1:0]  sw_op;
  logic [23:0] res_digits;
  logic [3:0]  operandX, operandY;
  logic        signX, signY, result_valid, err;
  logic [1:0]  op_sel;
  logic [23:0] disp;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  calc_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset(reset), .btn_enter(btn_enter), .btn_clear(btn_clear),
    .sw_value(sw_value), .sw_sign(sw_sign), .sw_op(sw_op), .res_digits(res_digits),
    .operandX(operandX), .signX(signX), .operandY(operandY), .signY(signY),
    .op_sel(op_sel), .disp(disp), .state(state), .result_valid(result_valid), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: which field is being collected plus periods left to settle.
  int          m_phase;
  int          m_left;
  logic [3:0]  m_x, m_y;
  logic        m_sx, m_sy, m_valid, m_err;
  logic [1:0]  m_op;
  logic [23:0] m_disp;

  task automatic model_clear();
    m_phase = 0; m_left = 0; m_x = 0; m_y = 0; m_sx = 0; m_sy = 0;
    m_op = 0; m_disp = 0; m_valid = 0; m_err = 0;
  endtask

  task automatic model_step();
    if (reset || btn_clear) begin
      model_clear();
    end else begin
      m_err = 1'b0;
      if (m_phase == 0 || m_phase == 1) begin
        if (btn_enter && sw_value > 9) m_err = 1'b1;
        else if (btn_enter) begin
          if (m_phase == 0) begin m_x = sw_value; m_sx = sw_sign; end
          else begin m_y = sw_value; m_sy = sw_sign; end
          m_phase = m_phase + 1;
        end
      end else if (m_phase == 2) begin
        if (btn_enter) begin m_op = sw_op; m_left = SETTLE; m_phase = 3; end
      end else if (m_phase == 3) begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_disp = res_digits; m_valid = 1'b1; m_phase = 4; end
      end else begin
        if (btn_enter) begin m_disp = 0; m_valid = 1'b0; m_phase = 0; end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of inputs, advances one edge and updates the model.
  task automatic cycle(input logic rst, input logic en, input logic clr, input logic [3:0] val,
                       input logic sgn, input logic [1:0] op, input logic [23:0] res);
    reset = rst; btn_enter = en; btn_clear = clr; sw_value = val;
    sw_sign = sgn; sw_op = op; res_digits = res;
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic rst, en, clr; logic [3:0] val; logic sgn; logic [1:0] op; logic [23:0] res;
    logic [2:0] st; logic [3:0] ox; logic sx; logic [3:0] oy; logic sy; logic [1:0] os;
    logic [23:0] dsp; logic vld; logic er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, en, clr, input logic [3:0] val, input logic sgn,
                              input logic [1:0] op, input logic [23:0] res, input logic [2:0] st,
                              input logic [3:0] ox, input logic sx, input logic [3:0] oy,
                              input logic sy, input logic [1:0] os, input logic [23:0] dsp,
                              input logic vld, er);
    vec_t v;
    v.rst = rst; v.en = en; v.clr = clr; v.val = val; v.sgn = sgn; v.op = op; v.res = res;
    v.st = st; v.ox = ox; v.sx = sx; v.oy = oy; v.sy = sy; v.os = os; v.dsp = dsp;
    v.vld = vld; v.er = er;
    return v;
  endfunction

  task automatic chk_outputs(input string tag, input logic [2:0] st, input logic [3:0] ox,
                             input logic sx, input logic [3:0] oy, input logic sy,
                             input logic [1:0] os, input logic [23:0] dsp, input logic vld,
                             input logic er);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".operandX"}, 32'(operandX), 32'(ox));
    chk({tag, ".signX"}, 32'(signX), 32'(sx));
    chk({tag, ".operandY"}, 32'(operandY), 32'(oy));
    chk({tag, ".signY"}, 32'(signY), 32'(sy));
    chk({tag, ".op_sel"}, 32'(op_sel), 32'(os));
    chk({tag, ".disp"}, 32'(disp), 32'(dsp));
    chk({tag, ".result_valid"}, 32'(result_valid), 32'(vld));
    chk({tag, ".err"}, 32'(err), 32'(er));
  endtask

  initial begin
    model_clear();
    //              rst en clr val sgn op res          st ox sx oy sy os disp        vld er
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 24'h0,      0, 0, 0, 0, 0, 0, 24'h0,      0, 0));
    tbl.push_back(mk(0, 1, 0, 7,  1, 0, 24'h0,      1, 7, 1, 0, 0, 0, 24'h0,      0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 0, 24'h0,      2, 7, 1, 0, 1, 0, 24'h0,      0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 24'h000107, 3, 7, 1, 0, 1, 0, 24'h0,      0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 24'h000107, 3, 7, 1, 0, 1, 0, 24'h0,      0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 24'h000107, 3, 7, 1, 0, 1, 0, 24'h0,      0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 24'h000107, 3, 7, 1, 0, 1, 0, 24'h0,      0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 24'h000107, 4, 7, 1, 0, 1, 0, 24'h000107, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 24'h0,      0, 7, 1, 0, 1, 0, 24'h0,      0, 0));
    tbl.push_back(mk(0, 1, 0, 12, 0, 0, 24'h0,      0, 7, 1, 0, 1, 0, 24'h0,      0, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 24'h0,      0, 7, 1, 0, 1, 0, 24'h0,      0, 0));
    tbl.push_back(mk(0, 1, 0, 9,  0, 0, 24'h0,      1, 9, 0, 0, 1, 0, 24'h0,      0, 0));
    tbl.push_back(mk(0, 1, 0, 3,  0, 0, 24'h0,      2, 9, 0, 3, 0, 0, 24'h0,      0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0, 2, 24'h111111, 3, 9, 0, 3, 0, 2, 24'h0,      0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 24'h111111, 3, 9, 0, 3, 0, 2, 24'h0,      0, 0));
    tbl.push_back(mk(0, 1, 0, 5,  1, 1, 24'h222222, 3, 9, 0, 3, 0, 2, 24'h0,      0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 24'h333333, 3, 9, 0, 3, 0, 2, 24'h0,      0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 24'h444444, 4, 9, 0, 3, 0, 2, 24'h444444, 1, 0));
    tbl.push_back(mk(0, 1, 1, 4,  0, 1, 24'h555555, 0, 0, 0, 0, 0, 0, 24'h0,      0, 0));
    tbl.push_back(mk(0, 1, 0, 5,  0, 0, 24'h0,      1, 5, 0, 0, 0, 0, 24'h0,      0, 0));
    tbl.push_back(mk(0, 1, 0, 6,  1, 0, 24'h0,      2, 5, 0, 6, 1, 0, 24'h0,      0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  0, 0, 24'h0,      0, 0, 0, 0, 0, 0, 24'h0,      0, 0));
    tbl.push_back(mk(0, 1, 0, 1,  0, 0, 24'h0,      1, 1, 0, 0, 0, 0, 24'h0,      0, 0));
    tbl.push_back(mk(0, 1, 0, 2,  0, 0, 24'h0,      2, 1, 0, 2, 0, 0, 24'h0,      0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0, 3, 24'habcdef, 3, 1, 0, 2, 0, 3, 24'h0,      0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 24'habcdef, 3, 1, 0, 2, 0, 3, 24'h0,      0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 24'habcdef, 3, 1, 0, 2, 0, 3, 24'h0,      0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  0, 0, 24'habcdef, 0, 0, 0, 0, 0, 0, 24'h0,      0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 24'habcdef, 0, 0, 0, 0, 0, 0, 24'h0,      0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 24'habcdef, 0, 0, 0, 0, 0, 0, 24'h0,      0, 0));

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].en, tbl[i].clr, tbl[i].val, tbl[i].sgn, tbl[i].op, tbl[i].res);
      chk_outputs($sformatf("vec%0d", i), tbl[i].st, tbl[i].ox, tbl[i].sx, tbl[i].oy,
                  tbl[i].sy, tbl[i].os, tbl[i].dsp, tbl[i].vld, tbl[i].er);
    end

    cycle(1, 0, 0, 0, 0, 0, 24'h0);
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 45),
            ($urandom_range(0, 99) < 4), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 24'($urandom));
      chk_outputs($sformatf("rnd%0d", n), 3'(m_phase), m_x, m_sx, m_y, m_sy, m_op, m_disp,
                  m_valid, m_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
